// File: rtl/lpc_sniffer_pkg.sv
// Shared LPC sniffer definitions: capture entry width, frame header bytes and
// the drain sequencer state encoding.
package lpc_sniffer_pkg;

  localparam int         LPC_DW       = 48;
  localparam logic [7:0] LPC_HDR_DATA = 8'hA5;
  localparam logic [7:0] LPC_HDR_DROP = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    HDR,
    DATA,
    DHDR,
    DCNT
  } rd_state_t;

endpackage

// File: rtl/ringbuffer_drain.sv
// Pops capture entries from the ring buffer and serializes them as A5-framed
// byte streams; overflow losses are reported in-band as 5A <count> frames.
module ringbuffer_drain
  import lpc_sniffer_pkg::*;
#(
  parameter int         DW       = LPC_DW,
  parameter int         NB       = DW / 8,
  parameter logic [7:0] HDR_DATA = LPC_HDR_DATA,
  parameter logic [7:0] HDR_DROP = LPC_HDR_DROP
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          rb_empty,
  input  logic [DW-1:0] rb_read_data,
  output logic          rb_read_enable,
  input  logic          rb_drop,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic [7:0]    drop_count
);

  localparam int            CW   = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  rd_state_t     state, state_nxt;
  logic [DW-1:0] shreg;
  logic [CW-1:0] bcnt;
  logic [7:0]    snap;
  logic          snap_en;

  // Everything moves on the falling edge to line up with the ring buffer.
  always_ff @(negedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Outputs decode straight from state so tx_valid drops with the async reset
  // and tx_data cannot change while a byte is stalled.
  always_comb begin
    state_nxt      = state;
    rb_read_enable = 1'b0;
    tx_valid       = 1'b0;
    tx_data        = '0;
    snap_en        = 1'b0;
    case (state)
      IDLE: begin
        if (run && drop_count != 8'd0) begin
          snap_en   = 1'b1;
          state_nxt = DHDR;
        end else if (run && !rb_empty) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        rb_read_enable = 1'b1;
        state_nxt      = LATCH;
      end
      LATCH: state_nxt = HDR;
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_DATA;
        if (tx_ready) state_nxt = DATA;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = shreg[DW-1 -: 8];
        if (tx_ready && bcnt == LAST) state_nxt = IDLE;
      end
      DHDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_DROP;
        if (tx_ready) state_nxt = DCNT;
      end
      DCNT: begin
        tx_valid = 1'b1;
        tx_data  = snap;
        if (tx_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      shreg      <= '0;
      bcnt       <= '0;
      snap       <= '0;
      drop_count <= '0;
    end else begin
      if (state == LATCH) begin
        shreg <= rb_read_data;
        bcnt  <= '0;
      end else if (state == DATA && tx_ready) begin
        shreg <= {shreg[DW-9:0], 8'h00};
        bcnt  <= bcnt + CW'(1);
      end
      // A drop landing on the snapshot edge starts the next report at 1.
      if (snap_en) begin
        snap       <= drop_count;
        drop_count <= {7'd0, rb_drop};
      end else if (rb_drop && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ringbuffer_drain.sv
// Directed bench for ringbuffer_drain: a queue-based ring buffer, a frame-level
// stream model checked every cycle, and literal byte sequences per scenario.
module tb_ringbuffer_drain;
  import lpc_sniffer_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              run = 1'b0;
  logic              rb_empty = 1'b1;
  logic              rb_drop = 1'b0;
  logic              tx_ready = 1'b1;
  logic [LPC_DW-1:0] rb_read_data = '0;
  logic              rb_read_enable, tx_valid, busy;
  logic [7:0]        tx_data, drop_count;

  int                n_vec = 0, n_err = 0;
  logic [LPC_DW-1:0] rbq[$];
  logic [7:0]        expq[$], obs[$], lit[$];
  logic [LPC_DW-1:0] m_e;
  int                m_drop = 0;
  int                fetch_cnt = 0;
  logic              prev_stall = 1'b0;
  logic [7:0]        prev_data = '0;
  logic [3:0]        pat = 4'b1001;

  always #5 clock = ~clock;

  ringbuffer_drain dut (
    .clock         (clock),
    .reset         (reset),
    .run           (run),
    .rb_empty      (rb_empty),
    .rb_read_data  (rb_read_data),
    .rb_read_enable(rb_read_enable),
    .rb_drop       (rb_drop),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .drop_count    (drop_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", nm, act, req);
    end
  endtask

  // Per-cycle compare plus the stream model; the model decides at each idle
  // cycle what frame (if any) must appear next and appends its bytes.
  task automatic cycle_check();
    if (!reset) begin
      expq.delete();
      m_drop     = 0;
      prev_stall = 1'b0;
    end else begin
      chk("drop_count", drop_count, 32'(m_drop));
      if (!busy) chk("idle_quiet", {tx_valid, rb_read_enable}, 2'b00);
      if (rb_read_enable) begin
        fetch_cnt++;
        chk("pop_while_empty", rb_empty, 1'b0);
      end
      if (prev_stall) chk("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
      if (tx_valid && tx_ready) begin
        obs.push_back(tx_data);
        if (expq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got 'h%0h, expected no byte", tx_data);
        end else begin
          chk("tx_byte", tx_data, expq.pop_front());
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (!busy && run && m_drop != 0) begin
        expq.push_back(LPC_HDR_DROP);
        expq.push_back(8'(m_drop));
        m_drop = rb_drop ? 1 : 0;
      end else begin
        if (!busy && run && !rb_empty) begin
          m_e = rbq[0];
          expq.push_back(LPC_HDR_DATA);
          for (int i = LPC_DW/8 - 1; i >= 0; i--) expq.push_back(m_e[i*8 +: 8]);
        end
        if (rb_drop && m_drop < 255) m_drop++;
      end
    end
  endtask

  // One clock: check at the rising edge, emulate the ring buffer pop on the
  // falling edge, and hand control back 2 time units later for input drive.
  task automatic step();
    logic pe;
    @(posedge clock);
    cycle_check();
    pe = rb_read_enable;
    @(negedge clock);
    if (pe && reset && rbq.size() > 0) rb_read_data = rbq.pop_front();
    #2;
    rb_empty = (rbq.size() == 0);
  endtask

  task automatic push(input logic [LPC_DW-1:0] e);
    rbq.push_back(e);
    rb_empty = 1'b0;
  endtask

  task automatic drain(input string nm, input bit stall);
    int streak = 0;
    int k = 0;
    while (streak < 3 && k < 300) begin
      if (stall) tx_ready = pat[k % 4];
      step();
      k++;
      if (expq.size() == 0 && !busy) streak++;
      else streak = 0;
    end
    tx_ready = 1'b1;
    if (streak < 3) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got %0d pending bytes, expected 0", nm, expq.size());
    end
  endtask

  task automatic cmp_obs(input string nm, input int base);
    chk({nm, "_len"}, obs.size() - base, lit.size());
    for (int i = 0; i < lit.size(); i++)
      if (base + i < obs.size()) chk(nm, obs[base + i], lit[i]);
  endtask

  initial begin
    int base, f0, k;
    step();
    step();
    chk("rst_rd_en", rb_read_enable, 1'b0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_drop", drop_count, 8'h00);
    reset = 1'b1;
    step();

    // single entry, free-running sink
    base = obs.size();
    f0   = fetch_cnt;
    push(48'h0123456789AB);
    run = 1'b1;
    step();
    step();
    drain("t1", 1'b0);
    lit = '{8'hA5, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    cmp_obs("t1_bytes", base);
    chk("t1_fetch", fetch_cnt - f0, 1);
    chk("t1_busy", busy, 1'b0);

    // same entry with a 1-0-0-1 ready pattern
    base = obs.size();
    push(48'h0123456789AB);
    step();
    step();
    drain("t2", 1'b1);
    cmp_obs("t2_bytes", base);

    // drops during a data frame are reported before the next data frame
    base = obs.size();
    push(48'h112233445566);
    step();
    step();
    rb_drop = 1'b1;
    repeat (3) step();
    rb_drop = 1'b0;
    push(48'hA1B2C3D4E5F6);
    drain("t3", 1'b0);
    lit = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h5A, 8'h03,
            8'hA5, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
    cmp_obs("t3_bytes", base);
    chk("t3_drop_clr", drop_count, 8'h00);

    // saturation, then a drop on the snapshot edge
    run     = 1'b0;
    rb_drop = 1'b1;
    repeat (300) step();
    rb_drop = 1'b0;
    step();
    chk("t4_sat", drop_count, 8'hFF);
    base    = obs.size();
    run     = 1'b1;
    rb_drop = 1'b1;
    step();
    rb_drop = 1'b0;
    chk("t4_snap_reload", drop_count, 8'h01);
    drain("t4", 1'b0);
    lit = '{8'h5A, 8'hFF, 8'h5A, 8'h01};
    cmp_obs("t4_bytes", base);

    // run dropped mid-frame: frame completes, nothing further is fetched
    run  = 1'b0;
    base = obs.size();
    push(48'h0F1E2D3C4B5A);
    push(48'hFFEEDDCCBBAA);
    run = 1'b1;
    k   = 0;
    while (obs.size() - base < 3 && k < 40) begin
      step();
      k++;
    end
    run = 1'b0;
    drain("t5", 1'b0);
    f0 = fetch_cnt;
    repeat (20) step();
    chk("t5_no_fetch", fetch_cnt - f0, 0);
    lit = '{8'hA5, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A};
    cmp_obs("t5_bytes", base);
    chk("t5_left", rbq.size(), 1);

    // reset in the middle of the data bytes
    base = obs.size();
    run  = 1'b1;
    k    = 0;
    while (obs.size() - base < 3 && k < 40) begin
      step();
      k++;
    end
    chk("t6_in_data", {busy, tx_valid}, 2'b11);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rd_en", rb_read_enable, 1'b0);
    chk("t6_valid", tx_valid, 1'b0);
    chk("t6_data", tx_data, 8'h00);
    chk("t6_busy", busy, 1'b0);
    chk("t6_drop", drop_count, 8'h00);
    rbq.delete();
    rb_empty = 1'b1;
    step();
    step();
    reset = 1'b1;
    repeat (10) begin
      step();
      chk("t6_idle_valid", tx_valid, 1'b0);
      chk("t6_idle_busy", busy, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ringbuffer_drain.md
# ringbuffer_drain

Read-side sequencer for the LPC capture ring buffer. It pops captured 48-bit LPC transaction entries whenever the buffer is non-empty and serializes each one as a framed byte stream over a valid/ready byte interface toward the UART transmitter. It also counts entries the buffer discarded on overflow and reports them in-band as drop frames, so the host can detect gaps.

## Interface
- DW, 48: ring buffer entry width; multiple of 8.
- NB, DW/8: data bytes per entry.
- HDR_DATA, 8'hA5: header byte of a data frame.
- HDR_DROP, 8'h5A: header byte of a drop frame.

- clock  in  1  system clock; all registers update on the falling edge, matching the ring buffer.
- reset  in  1  asynchronous, active-low; clears all state.
- run  in  1  level; when low, the current frame completes, then the block idles.
- rb_empty  in  1  ring buffer empty flag.
- rb_read_data  in  DW  ring buffer output word; valid the edge after the rb_read_enable edge.
- rb_read_enable  out  1  one-cycle pop strobe to the ring buffer.
- rb_drop  in  1  one-cycle pulse per entry discarded (write_enable & overflow).
- tx_data  out  8  byte to the transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte on an edge where tx_valid & tx_ready.
- busy  out  1  high in any state other than IDLE.
- drop_count  out  8  current saturating count of discarded entries not yet reported.

## Operation
- States: IDLE, FETCH, LATCH, HDR, DATA, DHDR, DCNT.
- IDLE: if run & drop_count!=0, go to DHDR and snapshot drop_count into the frame register. Else if run & !rb_empty, go to FETCH. Else stay. Drop reporting has priority over data.
- FETCH: rb_read_enable=1 for exactly this cycle, then LATCH. rb_read_enable is never asserted while rb_empty=1.
- LATCH: capture rb_read_data into the shift register, clear the byte counter, then HDR.
- HDR: tx_data=HDR_DATA. On handshake, go to DATA.
- DATA: tx_data = shift register MSB byte. On each handshake, shift left 8 and increment the counter. After byte NB-1 is accepted, go to IDLE.
- DHDR: tx_data=HDR_DROP. On handshake, go to DCNT.
- DCNT: tx_data = snapshot count. On handshake, go to IDLE.
- Frames are atomic: run is sampled only in IDLE.
- drop_count: +1 per rb_drop and saturates at 255. On the snapshot edge it loads 0, or 1 if rb_drop fires on that same edge. A snapshot of 0 is never emitted.
- tx_valid is high in HDR, DATA, DHDR and DCNT. While tx_valid & !tx_ready, tx_data is held stable.
- Reset mid-frame: the partial frame is abandoned and tx_valid drops asynchronously. The popped entry is lost; the ring buffer is reset by the same reset.

## Timing
- Reset values: rb_read_enable=0, tx_valid=0, tx_data=8'h00, busy=0, drop_count=0, state=IDLE.
- Pop latency: the FETCH edge after rb_empty falls (with run=1) is 1 cycle after IDLE samples it. tx_valid with the header rises 2 edges after the FETCH edge.
- With tx_ready held at 1, a data frame occupies 3+NB+1 cycles, IDLE to IDLE. A drop frame occupies 1+2 cycles.
- Back-to-back frames pass through IDLE for 1 cycle, so tx_valid deasserts for at least 1 cycle between frames.
- rb_empty is sampled only in IDLE. Because a pop is 1 cycle, the buffer empty flag has settled before the next IDLE.

## Structure
- Shared package lpc_sniffer_pkg holds:
  - the state enum;
  - HDR_DATA and HDR_DROP defaults;
  - the DW=48 entry-width constant, also used by the ring buffer instance.
- No sub-module: the FSM, shift register and drop counter stay inline (~150-250 lines). The block instantiates next to the ring buffer in the sniffer top.

## Test plan
- Single entry 48'h0123456789AB pushed, tx_ready=1 → one FETCH pulse, then bytes A5 01 23 45 67 89 AB. busy falls after the last byte.
- Same entry with tx_ready toggled 1-0-0-1 → no byte duplicated or skipped, and tx_data stays stable during stalls.
- 3 rb_drop pulses while a data frame is in flight, then the buffer holds another entry → frame finishes, then 5A 03 is emitted before the next A5 frame.
- 300 rb_drop pulses with run=0, then run=1 → drop_count saturates at 255 and 5A FF is emitted. If rb_drop fires on the snapshot edge, drop_count reads 1 afterwards.
- run deasserted during byte 3 of a data frame → frame completes with all 7 bytes, then no FETCH while the buffer is non-empty.
- reset asserted during the DATA state → all outputs go to reset values immediately. After release with an empty buffer, the block stays IDLE with no tx_valid.
